// File: rtl/up_link_pkg.sv
// Shared uplink definitions: frame headers, frame length and the
// state encodings of the byte and frame receivers.
package up_link_pkg;

  localparam logic [7:0] HEAD_VOLT_C  = 8'hA1;
  localparam logic [7:0] HEAD_STATE_C = 8'hA2;
  localparam logic [7:0] HEAD_FAULT_C = 8'hA5;
  localparam logic [7:0] HEAD_VER_C   = 8'hA6;

  localparam int FRAME_LEN = 3;

  typedef enum logic [1:0] {
    B_IDLE  = 2'd0,
    B_START = 2'd1,
    B_DATA  = 2'd2,
    B_STOP  = 2'd3
  } byte_st_e;

  typedef enum logic [1:0] {
    F_HEAD = 2'd0,
    F_HI   = 2'd1,
    F_LO   = 2'd2
  } frame_st_e;

endpackage

// File: rtl/uart_byte_rx.sv
// 8N1 byte receiver with 2-FF input synchronizer. byte_vld/byte_err are
// asserted combinationally in the cycle the stop bit is sampled.
module uart_byte_rx
  import up_link_pkg::*;
#(
  parameter logic [15:0] BIT_CYC = 16'd100
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rxd,
  output logic [7:0] byte_data,
  output logic       byte_vld,
  output logic       byte_err,
  output logic       idle
);

  localparam logic [15:0] HALF_M1 = (BIT_CYC / 16'd2) - 16'd1;
  localparam logic [15:0] FULL_M1 = BIT_CYC - 16'd1;

  logic       rxd_m, rxd_s, rxd_p;
  logic [15:0] cnt;
  logic [2:0] bit_idx;
  logic [7:0] shreg;
  byte_st_e   byte_state, byte_state_nxt;
  logic       tick;

  // Reset to idle-high so release never looks like a start edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
      rxd_p <= 1'b1;
    end else begin
      rxd_m <= rxd;
      rxd_s <= rxd_m;
      rxd_p <= rxd_s;
    end
  end

  assign tick = (cnt == 16'd0);

  always_comb begin
    byte_state_nxt = byte_state;
    byte_vld       = 1'b0;
    byte_err       = 1'b0;
    case (byte_state)
      B_IDLE:  if (rxd_p && !rxd_s) byte_state_nxt = B_START;
      B_START: if (tick) byte_state_nxt = rxd_s ? B_IDLE : B_DATA;
      B_DATA:  if (tick && (bit_idx == 3'd7)) byte_state_nxt = B_STOP;
      B_STOP: begin
        if (tick) begin
          byte_state_nxt = B_IDLE;
          byte_vld       = rxd_s;
          byte_err       = !rxd_s;
        end
      end
      default: byte_state_nxt = B_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      byte_state <= B_IDLE;
      cnt        <= 16'd0;
      bit_idx    <= 3'd0;
      shreg      <= 8'd0;
    end else begin
      byte_state <= byte_state_nxt;
      // Idle keeps the half-bit preload ready for the next start edge.
      if (byte_state == B_IDLE)  cnt <= HALF_M1;
      else if (tick)             cnt <= FULL_M1;
      else                       cnt <= cnt - 16'd1;
      if (byte_state == B_START) bit_idx <= 3'd0;
      else if ((byte_state == B_DATA) && tick) bit_idx <= bit_idx + 3'd1;
      if ((byte_state == B_DATA) && tick) shreg <= {rxd_s, shreg[7:1]};
    end
  end

  assign byte_data = shreg;
  assign idle      = (byte_state == B_IDLE);

endmodule

// File: rtl/up_sign_rx.sv
// Uplink frame receiver: assembles header/hi/lo frames, decodes them into
// registered outputs with strobes, and tracks link health and errors.
module up_sign_rx
  import up_link_pkg::*;
#(
  parameter logic [15:0] BIT_CYC    = 16'd100,
  parameter logic [15:0] GAP_CYC    = 16'd2000,
  parameter logic [23:0] LINK_TMO   = 24'd5000000,
  parameter logic [7:0]  HEAD_VOLT  = HEAD_VOLT_C,
  parameter logic [7:0]  HEAD_STATE = HEAD_STATE_C,
  parameter logic [7:0]  HEAD_FAULT = HEAD_FAULT_C,
  parameter logic [7:0]  HEAD_VER   = HEAD_VER_C
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        rxd,
  output logic [11:0] volt,
  output logic        volt_vld,
  output logic [15:0] state,
  output logic        state_vld,
  output logic [15:0] flt_state,
  output logic        flt_vld,
  output logic [15:0] ver,
  output logic        ver_vld,
  output logic        link_ok,
  output logic [7:0]  err_cnt
);

  logic [7:0]  byte_data;
  logic        byte_vld, byte_err, byte_idle;
  frame_st_e   frame_state, frame_state_nxt;
  logic [7:0]  head_q, hi_q;
  logic [15:0] gap_cnt;
  logic [23:0] link_cnt;
  logic [15:0] payload;
  logic        gap_abort, hdr_bad, volt_bad, frame_done, err_evt, is_head;

  uart_byte_rx #(.BIT_CYC(BIT_CYC)) u_byte (
    .clk       (clk),
    .rstn      (rstn),
    .rxd       (rxd),
    .byte_data (byte_data),
    .byte_vld  (byte_vld),
    .byte_err  (byte_err),
    .idle      (byte_idle)
  );

  assign payload   = {hi_q, byte_data};
  assign is_head   = (byte_data == HEAD_VOLT) || (byte_data == HEAD_STATE) ||
                     (byte_data == HEAD_FAULT) || (byte_data == HEAD_VER);
  assign gap_abort = (frame_state != F_HEAD) && byte_idle && (gap_cnt == GAP_CYC - 16'd1);

  always_comb begin
    frame_state_nxt = frame_state;
    hdr_bad         = 1'b0;
    volt_bad        = 1'b0;
    frame_done      = 1'b0;
    if (byte_err || gap_abort) begin
      frame_state_nxt = F_HEAD;
    end else if (byte_vld) begin
      case (frame_state)
        F_HEAD: if (is_head) frame_state_nxt = F_HI; else hdr_bad = 1'b1;
        F_HI:   frame_state_nxt = F_LO;
        F_LO: begin
          frame_state_nxt = F_HEAD;
          if ((head_q == HEAD_VOLT) && (payload[15:12] != 4'd0)) volt_bad = 1'b1;
          else frame_done = 1'b1;
        end
        default: frame_state_nxt = F_HEAD;
      endcase
    end
  end

  assign err_evt = byte_err | gap_abort | hdr_bad | volt_bad;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      frame_state <= F_HEAD;
      head_q      <= 8'd0;
      hi_q        <= 8'd0;
      gap_cnt     <= 16'd0;
      link_cnt    <= 24'd0;
      link_ok     <= 1'b0;
      err_cnt     <= 8'd0;
      volt        <= 12'd0;
      volt_vld    <= 1'b0;
      state       <= 16'd0;
      state_vld   <= 1'b0;
      flt_state   <= 16'd0;
      flt_vld     <= 1'b0;
      ver         <= 16'd0;
      ver_vld     <= 1'b0;
    end else begin
      frame_state <= frame_state_nxt;
      volt_vld    <= 1'b0;
      state_vld   <= 1'b0;
      flt_vld     <= 1'b0;
      ver_vld     <= 1'b0;
      if (byte_vld && (frame_state == F_HEAD) && is_head) head_q <= byte_data;
      if (byte_vld && (frame_state == F_HI)) hi_q <= byte_data;

      // Gap timer only runs between bytes of a frame in progress.
      if (byte_vld || (frame_state == F_HEAD) || gap_abort) gap_cnt <= 16'd0;
      else if (byte_idle) gap_cnt <= gap_cnt + 16'd1;

      if (err_evt && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;

      if (frame_done) begin
        case (head_q)
          HEAD_VOLT:  begin volt      <= payload[11:0]; volt_vld  <= 1'b1; end
          HEAD_STATE: begin state     <= payload;       state_vld <= 1'b1; end
          HEAD_FAULT: begin flt_state <= payload;       flt_vld   <= 1'b1; end
          HEAD_VER:   begin ver       <= payload;       ver_vld   <= 1'b1; end
          default: ;
        endcase
      end

      if (frame_done) begin
        link_cnt <= 24'd0;
        link_ok  <= 1'b1;
      end else if (link_cnt != LINK_TMO) begin
        link_cnt <= link_cnt + 24'd1;
        if (link_cnt == LINK_TMO - 24'd1) link_ok <= 1'b0;
      end
    end
  end

endmodule

// File: doc/up_sign_rx.md
Name: up_sign_rx

Overview:
Controller-side receiver for the power-unit uplink. It sits directly downstream of the unit's uplink transmitter and receives serial 3-byte frames on rxd. Each frame is a header byte followed by a 16-bit payload. The block validates and decodes each frame into registered voltage, state, fault-state and version outputs, each with a one-cycle strobe, and reports link health and an error count.

Parameters:
BIT_CYC, 16'd100, clk cycles per serial bit (>=8)
GAP_CYC, 16'd2000, max idle cycles between bytes of one frame before assembly aborts
LINK_TMO, 24'd5000000, clk cycles without a good frame before link_ok drops
HEAD_VOLT, 8'hA1, voltage frame header
HEAD_STATE, 8'hA2, periodic state frame header
HEAD_FAULT, 8'hA5, fault event frame header
HEAD_VER, 8'hA6, version frame header

Ports:
clk  in  1  system clock
rstn  in  1  reset
rxd  in  1  serial input, idle high, asynchronous to clk
volt  out  12  last received module voltage
volt_vld  out  1  1-cycle strobe, volt updated
state  out  16  last received state word (A2)
state_vld  out  1  1-cycle strobe, state updated
flt_state  out  16  state word captured by last fault frame (A5)
flt_vld  out  1  1-cycle strobe, fault frame received
ver  out  16  last received version word
ver_vld  out  1  1-cycle strobe, ver updated
link_ok  out  1  high while good frames arrive within LINK_TMO
err_cnt  out  8  saturating count of rejected bytes/frames

Behaviour:
- Reset: rstn is asynchronous, active-low; clock is clk. All outputs reset to 0, including link_ok=0. The byte FSM returns to IDLE and the frame FSM returns to F_HEAD.
- Line format: 8N1, LSB first. The frame is 3 bytes sent in order header, payload[15:8], payload[7:0].
- rxd passes through a 2-FF synchronizer; all logic uses the synchronized signal.
- Byte FSM:
  - IDLE: a falling edge enters START with the bit counter set to BIT_CYC/2.
  - START: at mid-bit, if rxd=1 (glitch), return to IDLE with no error. Otherwise go to DATA.
  - DATA: sample 8 bits, each BIT_CYC apart at mid-bit.
  - STOP: sample at mid-bit. If 1, emit byte_vld for 1 cycle with the data. If 0, emit byte_err. In both cases return to IDLE.
  - The next start edge is accepted immediately after the STOP sample.
- Frame FSM:
  - F_HEAD: on byte_vld, if the byte equals one of the 4 headers, latch it and go to F_HI. Any other byte increments err_cnt and stays in F_HEAD.
  - F_HI: latch the high byte, go to F_LO.
  - F_LO: latch the low byte and run the decode rules below. Always return to F_HEAD.
- Decode in F_LO:
  - A1 with payload[15:12]==0: volt<=payload[11:0], volt_vld pulse.
  - A1 with payload[15:12]!=0: err_cnt increments, no update.
  - A2: state, state_vld.
  - A5: flt_state, flt_vld.
  - A6: ver, ver_vld.
- Strobe latency: outputs and the strobe are registered and appear on the clk after the cycle in which the final stop-bit sample is accepted. Data remains stable until the next valid frame of the same type.
- Gap timer: counts idle cycles while in F_HI or F_LO with the byte FSM in IDLE. When it reaches GAP_CYC, the frame aborts to F_HEAD and err_cnt increments. The timer clears on each accepted byte.
- byte_err in any frame state: err_cnt increments and the frame FSM returns to F_HEAD.
- err_cnt saturates at 8'hFF and never wraps. If an error and a good frame occur in the same cycle, only the error increments err_cnt.
- Link timer: clears to 0 and sets link_ok=1 on every decoded good frame. Otherwise it increments. When it reaches LINK_TMO, link_ok<=0 and the timer holds its value (no wrap).
- rxd stuck low: a single START/DATA/STOP cycle yields byte_err. After that no new falling edge occurs, so no further errors are counted; link_ok eventually drops.
- Reset mid-byte or mid-frame discards the partial data. After release, reception begins only at the next falling edge.

Decomposition:
- Shared package up_link_pkg holds:
  - header constants A1/A2/A5/A6, shared with the transmitter;
  - the frame length constant (3 bytes);
  - byte-FSM and frame-FSM state encodings.
- One sub-module, uart_byte_rx, contains the synchronizer, the byte FSM, and outputs byte_data[7:0], byte_vld and byte_err, plus an idle flag. The top level holds the frame FSM, gap/link timers, decode and err_cnt.

Test Plan:
- Send A2 12 34 at BIT_CYC=100 -> state=16'h1234 with a single state_vld pulse; link_ok rises; err_cnt=0.
- Send A1 0F FF, then A1 1F FF -> volt=12'hFFF after the first frame; the second is rejected, so volt is unchanged and err_cnt=1.
- Send A5 00 80, then A6 40 11 back-to-back with zero inter-frame gap -> flt_state=16'h0080 with flt_vld, then ver=16'h4011 with ver_vld; each strobe lasts exactly one cycle.
- Send 55 A2 AB CD -> 55 is rejected with err_cnt+1, then state=16'hABCD.
- Send A2 12, idle > GAP_CYC, then send 34 56 -> frame aborts (err_cnt+1). 34 is rejected as a header (err_cnt+1), and 56 is rejected (err_cnt+1). state is not updated.
- Error and timeout corner cases:
  - A byte with stop bit = 0 -> err_cnt+1 and frame resync.
  - No frames for LINK_TMO cycles -> link_ok=0.
  - 300 bad bytes -> err_cnt holds at 8'hFF.
  - rstn asserted mid-byte -> all outputs return to 0.
